// File: rtl/vid_pkg.sv
// Shared video definitions for the line capture slice.
// Holds the default pixel geometry, the capture state encoding and a helper
// that packs one RGB pixel with channel 0 (R) in the least significant bits.
package vid_pkg;

  localparam int CH_W_DEF = 8;
  localparam int NCH_DEF  = 3;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    BLANK     = 2'd1,
    CAPTURE   = 2'd2
  } cap_state_t;

  // Packs R, G and B into one word, R lowest, B highest.
  function automatic logic [NCH_DEF*CH_W_DEF-1:0] pack_rgb(
    input logic [CH_W_DEF-1:0] r,
    input logic [CH_W_DEF-1:0] g,
    input logic [CH_W_DEF-1:0] b
  );
    return {b, g, r};
  endfunction

endpackage

// File: rtl/line_bank_ram.sv
// Two-bank line store: simple dual-port RAM with one write port and one
// registered read port, addressed as {bank, addr}.
// Ports:
//   clk    - system clock
//   rst    - synchronous active-low reset (clears only the read register)
//   we     - write enable
//   wbank  - bank selected for the write
//   waddr  - pixel address within the write bank
//   wdata  - pixel written
//   rbank  - bank selected for the read
//   raddr  - pixel address within the read bank
//   rdata  - registered read data, 1-cycle latency; 0 for raddr >= DEPTH
module line_bank_ram #(
  parameter int DW    = 24,
  parameter int DEPTH = 640,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          wbank,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          rbank,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  // Concatenated {bank, addr} indexing keeps the address decode trivial;
  // when DEPTH is not a power of two the top of each bank is simply unused.
  logic [DW-1:0] mem [2**(AW+1)];

  logic raddr_oob;
  assign raddr_oob = ({1'b0, raddr} >= (AW+1)'(DEPTH));

  // Storage has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[{wbank, waddr}] <= wdata;
    end
  end

  // Output register; reset and out-of-range reads both return zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata <= '0;
    end else if (raddr_oob) begin
      rdata <= '0;
    end else begin
      rdata <= mem[{rbank, raddr}];
    end
  end

endmodule

// File: rtl/line_capture_pingpong.sv
// Ping-pong line capture: writes one hsync-delimited line of valid pixels
// into the capture bank and, at the line boundary, commits it to the read
// side while capture carries on into the other bank.
// Ports:
//   clk        - system clock
//   rst        - synchronous active-low reset
//   hsync      - line sync, high during blanking
//   pix_valid  - pixel qualifier
//   pix_data   - packed pixel, channel 0 in LSBs
//   rd_addr    - read address into the committed bank
//   rd_data    - committed-bank pixel, 1-cycle latency
//   line_ready - one-cycle pulse when a non-empty line is committed
//   line_len   - pixel count of the committed line
//   line_ovf   - committed line had more than HSIZE pixels
//   full       - capture bank holds HSIZE pixels
module line_capture_pingpong
  import vid_pkg::*;
#(
  parameter int CH_W  = CH_W_DEF,
  parameter int NCH   = NCH_DEF,
  parameter int HSIZE = 640,
  parameter int AW    = $clog2(HSIZE),
  parameter int LW    = $clog2(HSIZE+1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hsync,
  input  logic                pix_valid,
  input  logic [NCH*CH_W-1:0] pix_data,
  input  logic [AW-1:0]       rd_addr,
  output logic [NCH*CH_W-1:0] rd_data,
  output logic                line_ready,
  output logic [LW-1:0]       line_len,
  output logic                line_ovf,
  output logic                full
);

  cap_state_t state, next_state;

  logic          wr_bank;
  logic [LW-1:0] wr_ptr;
  logic          ovf_acc;

  logic          wr_en;
  logic          drop_ovf;
  logic          commit;
  logic          at_limit;

  assign at_limit = (wr_ptr == LW'(HSIZE));

  // Next-state and per-cycle strobes. A pixel arriving with hsync high in
  // CAPTURE is part of blanking and is dropped by the commit branch.
  always_comb begin
    next_state = state;
    wr_en      = 1'b0;
    drop_ovf   = 1'b0;
    commit     = 1'b0;
    full       = 1'b0;
    case (state)
      WAIT_SYNC: begin
        if (hsync) next_state = BLANK;
      end
      BLANK: begin
        if (!hsync) next_state = CAPTURE;
      end
      CAPTURE: begin
        full = at_limit;
        if (hsync) begin
          commit     = 1'b1;
          next_state = BLANK;
        end else if (pix_valid) begin
          wr_en    = !at_limit;
          drop_ovf = at_limit;
        end
      end
      default: begin
        next_state = WAIT_SYNC;
      end
    endcase
  end

  // State, write pointer and commit bookkeeping. An empty line leaves the
  // previously committed line visible and raises no pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= WAIT_SYNC;
      wr_bank    <= 1'b0;
      wr_ptr     <= '0;
      ovf_acc    <= 1'b0;
      line_ready <= 1'b0;
      line_len   <= '0;
      line_ovf   <= 1'b0;
    end else begin
      state      <= next_state;
      line_ready <= 1'b0;
      if (wr_en) begin
        wr_ptr <= wr_ptr + LW'(1);
      end
      if (drop_ovf) begin
        ovf_acc <= 1'b1;
      end
      if (commit) begin
        wr_ptr  <= '0;
        ovf_acc <= 1'b0;
        if (wr_ptr != '0) begin
          wr_bank    <= ~wr_bank;
          line_len   <= wr_ptr;
          line_ovf   <= ovf_acc;
          line_ready <= 1'b1;
        end
      end
    end
  end

  // The read side always looks at the bank not being written.
  line_bank_ram #(
    .DW    (NCH*CH_W),
    .DEPTH (HSIZE),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .wbank (wr_bank),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (pix_data),
    .rbank (~wr_bank),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_line_capture_pingpong.sv
// Self-checking bench for line_capture_pingpong with an 8-pixel line.
// A vector table covers the basic line; hand-written sequences cover
// overflow, gapped strobes, empty lines, ping-pong isolation and reset.
module tb_line_capture_pingpong;
  import vid_pkg::*;

  localparam int HSIZE = 8;
  localparam int AW    = 3;
  localparam int LW    = 4;
  localparam int DW    = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          hsync;
  logic          pix_valid;
  logic [DW-1:0] pix_data;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          line_ready;
  logic [LW-1:0] line_len;
  logic          line_ovf;
  logic          full;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic          hs;
    logic          pv;
    logic [DW-1:0] pd;
    logic [AW-1:0] ra;
    logic          e_ready;
    logic [LW-1:0] e_len;
    logic          e_ovf;
    logic          e_full;
    logic          c_rd;
    logic [DW-1:0] e_rd;
  } vec_t;

  vec_t tbl [11];
  logic [DW-1:0] exp_px [16];
  logic [DW-1:0] line_a [3];

  line_capture_pingpong #(
    .CH_W  (8),
    .NCH   (3),
    .HSIZE (HSIZE),
    .AW    (AW),
    .LW    (LW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .hsync      (hsync),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .line_ready (line_ready),
    .line_len   (line_len),
    .line_ovf   (line_ovf),
    .full       (full)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, then sample 1 ns after the clock edge.
  task automatic applyStimulus(input logic hs, input logic pv,
                               input logic [DW-1:0] pd, input logic [AW-1:0] ra);
    hsync     = hs;
    pix_valid = pv;
    pix_data  = pd;
    rd_addr   = ra;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    // Basic 4-pixel line: sync, capture, commit, read back.
    tbl[0]  = '{1'b1, 1'b0, 24'h0, 3'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 24'h0};
    tbl[1]  = '{1'b0, 1'b1, 24'hEEEEEE, 3'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 24'h0};
    tbl[2]  = '{1'b0, 1'b1, 24'h010203, 3'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 24'h0};
    tbl[3]  = '{1'b0, 1'b1, 24'h040506, 3'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 24'h0};
    tbl[4]  = '{1'b0, 1'b1, 24'h070809, 3'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 24'h0};
    tbl[5]  = '{1'b0, 1'b1, 24'h0A0B0C, 3'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 24'h0};
    tbl[6]  = '{1'b1, 1'b1, 24'hDDDDDD, 3'd0, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 24'h0};
    tbl[7]  = '{1'b1, 1'b0, 24'h0, 3'd0, 1'b0, 4'd4, 1'b0, 1'b0, 1'b1, 24'h010203};
    tbl[8]  = '{1'b1, 1'b0, 24'h0, 3'd1, 1'b0, 4'd4, 1'b0, 1'b0, 1'b1, 24'h040506};
    tbl[9]  = '{1'b1, 1'b0, 24'h0, 3'd2, 1'b0, 4'd4, 1'b0, 1'b0, 1'b1, 24'h070809};
    tbl[10] = '{1'b1, 1'b0, 24'h0, 3'd3, 1'b0, 4'd4, 1'b0, 1'b0, 1'b1, 24'h0A0B0C};

    rst = 1'b0; hsync = 1'b0; pix_valid = 1'b0; pix_data = '0; rd_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ready", 32'(line_ready), 32'd0);
    checkOutput("rst_len",   32'(line_len),   32'd0);
    checkOutput("rst_ovf",   32'(line_ovf),   32'd0);
    checkOutput("rst_rd",    32'(rd_data),    32'd0);
    checkOutput("rst_full",  32'(full),       32'd0);
    rst = 1'b1;

    checkOutput("pack_rgb", 32'(pack_rgb(8'h03, 8'h02, 8'h01)), 32'h010203);

    for (int i = 0; i < 11; i++) begin
      applyStimulus(tbl[i].hs, tbl[i].pv, tbl[i].pd, tbl[i].ra);
      checkOutput($sformatf("t1_ready[%0d]", i), 32'(line_ready), 32'(tbl[i].e_ready));
      checkOutput($sformatf("t1_len[%0d]", i),   32'(line_len),   32'(tbl[i].e_len));
      checkOutput($sformatf("t1_ovf[%0d]", i),   32'(line_ovf),   32'(tbl[i].e_ovf));
      checkOutput($sformatf("t1_full[%0d]", i),  32'(full),       32'(tbl[i].e_full));
      if (tbl[i].c_rd)
        checkOutput($sformatf("t1_rd[%0d]", i), 32'(rd_data), 32'(tbl[i].e_rd));
    end

    // Overflow: 11 pixels into an 8-deep bank.
    $display("[TB] overflow line");
    applyStimulus(1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 11; i++) begin
      exp_px[i] = 24'h200000 + 24'(i);
      applyStimulus(1'b0, 1'b1, exp_px[i], '0);
      if (i == 6) checkOutput("t2_full_before", 32'(full), 32'd0);
      if (i == 7) checkOutput("t2_full_at8",    32'(full), 32'd1);
      if (i == 10) checkOutput("t2_full_held",  32'(full), 32'd1);
    end
    applyStimulus(1'b1, 1'b0, '0, 3'd7);
    checkOutput("t2_ready", 32'(line_ready), 32'd1);
    checkOutput("t2_len",   32'(line_len),   32'd8);
    checkOutput("t2_ovf",   32'(line_ovf),   32'd1);
    checkOutput("t2_full_blank", 32'(full),  32'd0);
    applyStimulus(1'b1, 1'b0, '0, 3'd7);
    checkOutput("t2_ready_low", 32'(line_ready), 32'd0);
    checkOutput("t2_rd7", 32'(rd_data), 32'(exp_px[7]));
    applyStimulus(1'b0, 1'b0, '0, '0);
    applyStimulus(1'b0, 1'b1, 24'h300000, '0);
    applyStimulus(1'b0, 1'b1, 24'h300001, '0);
    applyStimulus(1'b1, 1'b0, '0, '0);
    checkOutput("t2b_ready", 32'(line_ready), 32'd1);
    checkOutput("t2b_len",   32'(line_len),   32'd2);
    checkOutput("t2b_ovf",   32'(line_ovf),   32'd0);

    // Gapped strobes: valid on every other cycle over 12 cycles.
    $display("[TB] gapped strobes");
    applyStimulus(1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0) exp_px[i/2] = 24'h400000 + 24'(i);
      applyStimulus(1'b0, (i % 2 == 0), 24'h400000 + 24'(i), '0);
    end
    applyStimulus(1'b1, 1'b0, '0, '0);
    checkOutput("t3_ready", 32'(line_ready), 32'd1);
    checkOutput("t3_len",   32'(line_len),   32'd6);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, 1'b0, '0, AW'(k));
      checkOutput($sformatf("t3_rd[%0d]", k), 32'(rd_data), 32'(exp_px[k]));
    end

    // Five-pixel line followed by an empty line.
    $display("[TB] empty line");
    applyStimulus(1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 5; i++) begin
      exp_px[i] = 24'h500000 + 24'(i);
      applyStimulus(1'b0, 1'b1, exp_px[i], '0);
    end
    applyStimulus(1'b1, 1'b0, '0, '0);
    checkOutput("t4_ready", 32'(line_ready), 32'd1);
    checkOutput("t4_len",   32'(line_len),   32'd5);
    applyStimulus(1'b0, 1'b0, '0, '0);
    applyStimulus(1'b0, 1'b0, '0, '0);
    applyStimulus(1'b1, 1'b0, '0, '0);
    checkOutput("t4_empty_ready", 32'(line_ready), 32'd0);
    applyStimulus(1'b1, 1'b0, '0, '0);
    checkOutput("t4_empty_ready2", 32'(line_ready), 32'd0);
    checkOutput("t4_empty_len",    32'(line_len),   32'd5);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 1'b0, '0, AW'(k));
      checkOutput($sformatf("t4_rd[%0d]", k), 32'(rd_data), 32'(exp_px[k]));
    end

    // Line A committed, then read while line B is captured.
    $display("[TB] ping-pong isolation");
    applyStimulus(1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      line_a[i] = pack_rgb(8'hA0 + 8'(i), 8'hA1, 8'hA2);
      applyStimulus(1'b0, 1'b1, line_a[i], '0);
    end
    applyStimulus(1'b1, 1'b0, '0, '0);
    checkOutput("t5a_len", 32'(line_len), 32'd3);
    applyStimulus(1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 5; i++) begin
      exp_px[i] = pack_rgb(8'hB0 + 8'(i), 8'hB1, 8'hB2);
      applyStimulus(1'b0, 1'b1, exp_px[i], AW'(i % 3));
      checkOutput($sformatf("t5_rdA[%0d]", i), 32'(rd_data), 32'(line_a[i % 3]));
    end
    applyStimulus(1'b1, 1'b0, '0, '0);
    checkOutput("t5b_ready", 32'(line_ready), 32'd1);
    checkOutput("t5b_len",   32'(line_len),   32'd5);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 1'b0, '0, AW'(k));
      checkOutput($sformatf("t5_rdB[%0d]", k), 32'(rd_data), 32'(exp_px[k]));
    end

    // Reset in the middle of a line, then pixels before any sync.
    $display("[TB] mid-line reset");
    applyStimulus(1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 24'h600000 + 24'(i), '0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b1, 24'h6000FF, '0);
    checkOutput("t6_rst_ready", 32'(line_ready), 32'd0);
    checkOutput("t6_rst_len",   32'(line_len),   32'd0);
    checkOutput("t6_rst_rd",    32'(rd_data),    32'd0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 24'h610000 + 24'(i), '0);
      checkOutput($sformatf("t6_ws_ready[%0d]", i), 32'(line_ready), 32'd0);
    end
    applyStimulus(1'b1, 1'b0, '0, '0);
    checkOutput("t6_blank_ready", 32'(line_ready), 32'd0);
    applyStimulus(1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      exp_px[i] = 24'h700000 + 24'(i);
      applyStimulus(1'b0, 1'b1, exp_px[i], '0);
      checkOutput($sformatf("t6_cap_ready[%0d]", i), 32'(line_ready), 32'd0);
    end
    applyStimulus(1'b1, 1'b0, '0, '0);
    checkOutput("t6_ready", 32'(line_ready), 32'd1);
    checkOutput("t6_len",   32'(line_len),   32'd4);
    checkOutput("t6_ovf",   32'(line_ovf),   32'd0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, '0, AW'(k));
      checkOutput($sformatf("t6_after_ready[%0d]", k), 32'(line_ready), 32'd0);
      checkOutput($sformatf("t6_rd[%0d]", k), 32'(rd_data), 32'(exp_px[k]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
